// File: rtl/alu_rs.sv
// Four-entry age-ordered reservation station in front of the integer ALU.
// Collapsing queue: entry 0 is oldest, issue picks the oldest fully-ready entry.
module alu_rs #(
    parameter int BW    = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int OP_W  = 4
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OP_W-1:0]            disp_choice,
    input  logic                       disp_src1_rdy,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic [BW-1:0]              disp_src1_val,
    input  logic                       disp_src2_rdy,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    input  logic [BW-1:0]              disp_src2_val,
    input  logic [TAG_W-1:0]           disp_dst_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [BW-1:0]              cdb_data,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [BW-1:0]              iss_d1,
    output logic [BW-1:0]              iss_d2,
    output logic [OP_W-1:0]            iss_choice,
    output logic [TAG_W-1:0]           iss_dst_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [OP_W-1:0]  choice;
        logic [TAG_W-1:0] dst_tag;
        logic             s1_rdy;
        logic [TAG_W-1:0] s1_tag;
        logic [BW-1:0]    s1_val;
        logic             s2_rdy;
        logic [TAG_W-1:0] s2_tag;
        logic [BW-1:0]    s2_val;
    } entry_t;

    // Capture a CDB broadcast into any still-waiting source of an entry.
    function automatic entry_t wake(input entry_t e, input logic v,
                                    input logic [TAG_W-1:0] t, input logic [BW-1:0] d);
        entry_t r;
        r = e;
        if (v && !e.s1_rdy && (e.s1_tag == t)) begin
            r.s1_rdy = 1'b1;
            r.s1_val = d;
        end
        if (v && !e.s2_rdy && (e.s2_tag == t)) begin
            r.s2_rdy = 1'b1;
            r.s2_val = d;
        end
        return r;
    endfunction

    entry_t         ent [DEPTH];
    entry_t         cur [DEPTH+1];
    entry_t         nxt [DEPTH];
    entry_t         new_ent;
    logic [CW-1:0]  nxt_count;
    int             sel_idx;
    int             wr_idx;
    logic           iss_fire;
    logic           disp_fire;

    assign disp_ready = (int'(count) < DEPTH);
    assign disp_fire  = disp_valid && disp_ready;
    assign iss_fire   = iss_valid && iss_ready;

    // Oldest-first select: scanning downward leaves the lowest ready index.
    always_comb begin
        iss_valid   = 1'b0;
        sel_idx     = DEPTH;
        iss_d1      = '0;
        iss_d2      = '0;
        iss_choice  = '0;
        iss_dst_tag = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if ((i < int'(count)) && ent[i].s1_rdy && ent[i].s2_rdy) begin
                iss_valid   = 1'b1;
                sel_idx     = i;
                iss_d1      = ent[i].s1_val;
                iss_d2      = ent[i].s2_val;
                iss_choice  = ent[i].choice;
                iss_dst_tag = ent[i].dst_tag;
            end
        end
    end

    // Padded copy so slot j can always look one index up during the shift.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            cur[j] = ent[j];
        end
        cur[DEPTH] = '0;
    end

    always_comb begin
        new_ent.choice  = disp_choice;
        new_ent.dst_tag = disp_dst_tag;
        new_ent.s1_rdy  = disp_src1_rdy;
        new_ent.s1_tag  = disp_src1_tag;
        new_ent.s1_val  = disp_src1_val;
        new_ent.s2_rdy  = disp_src2_rdy;
        new_ent.s2_tag  = disp_src2_tag;
        new_ent.s2_val  = disp_src2_val;
        new_ent         = wake(new_ent, cdb_valid, cdb_tag, cdb_data);
        wr_idx          = int'(count) - (iss_fire ? 1 : 0);
        nxt_count       = count + CW'(disp_fire) - CW'(iss_fire);
        for (int j = 0; j < DEPTH; j++) begin
            logic shift;
            int   src;
            shift = iss_fire && (j >= sel_idx);
            src   = shift ? j + 1 : j;
            if (src < int'(count)) begin
                nxt[j] = wake(shift ? cur[j+1] : cur[j], cdb_valid, cdb_tag, cdb_data);
            end else begin
                nxt[j] = '0;
            end
            if (disp_fire && (j == wr_idx)) begin
                nxt[j] = new_ent;
            end
        end
    end

    // Flush wipes the queue and discards any same-cycle dispatch or issue.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                ent[j] <= '0;
            end
        end else if (flush) begin
            count <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                ent[j] <= '0;
            end
        end else begin
            count <= nxt_count;
            for (int j = 0; j < DEPTH; j++) begin
                ent[j] <= nxt[j];
            end
        end
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- 4-entry, age-ordered reservation station sitting directly in front of the integer ALU.
- Accepts renamed instructions from dispatch and captures missing source operands from the common data bus (CDB).
- Issues the oldest instruction with both operands ready to the ALU as d1/d2/choice, plus its destination tag.
- It is the producer side of the ALU operand interface; the ALU consumes what it issues.

Parameters:
- BW, 32, operand/data width.
- DEPTH, 4, number of entries (≥2).
- TAG_W, 6, physical-register tag width.
- OP_W, 4, ALU choice code width (matches ALU choice port).

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; synchronous.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  RS can accept (count < DEPTH).
- disp_choice  in  OP_W  ALU operation code.
- disp_src1_rdy  in  1  src1 value already valid.
- disp_src1_tag  in  TAG_W  src1 producer tag.
- disp_src1_val  in  BW  src1 value (used if rdy).
- disp_src2_rdy, disp_src2_tag, disp_src2_val  in  1/TAG_W/BW  same for src2.
- disp_dst_tag  in  TAG_W  destination tag.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  BW  broadcast value.
- iss_valid  out  1  an instruction is offered to the ALU.
- iss_ready  in  1  ALU/writeback accepts the offer this cycle.
- iss_d1  out  BW  ALU d1.
- iss_d2  out  BW  ALU d2.
- iss_choice  out  OP_W  ALU choice.
- iss_dst_tag  out  TAG_W  result tag.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Storage: collapsing queue. Entry 0 is the oldest; valid entries are always contiguous 0..count-1.
- Each entry holds: choice, dst_tag, and per source {rdy, tag, val}.
- Reset (rst_n low, async): all entries invalid, count=0, all rdy bits 0. Consequently iss_valid=0, iss_d1/iss_d2/iss_choice/iss_dst_tag=0, disp_ready=1.
- Select (combinational from registered state): pick the lowest index i with src1.rdy & src2.rdy.
  - iss_valid=1 when such an i exists.
  - iss_* fields come from entry i; all are 0 when iss_valid=0.
  - Offer may change cycle to cycle while iss_ready=0 (an older entry becoming ready takes priority); no stickiness is required.
- Issue handshake: when iss_valid & iss_ready at a rising edge, entry i is removed and entries i+1..count-1 shift down one index.
- Dispatch:
  - disp_ready = (count < DEPTH), derived from registered count only; a same-cycle issue does not raise it.
  - disp_valid & disp_ready writes the new entry at index count, or count-1 if an issue also fires that cycle.
  - disp_valid while disp_ready=0 is ignored.
- Wakeup: on cdb_valid, every valid entry source with rdy=0 and tag==cdb_tag sets rdy=1 and val=cdb_data at the edge.
  - The woken entry becomes selectable the next cycle; there is no same-cycle wake-to-issue.
  - The shift-down and the wakeup apply together: a shifted entry captures the CDB value at its new index.
- Dispatch bypass: if an incoming source has rdy=0 and cdb_valid & cdb_tag==src_tag in the same cycle, it is written with rdy=1 and val=cdb_data.
- Both sources matching the same broadcast: both capture.
- CDB tag matching an already-ready source: no change.
- count update: next = count + (dispatch fire) − (issue fire). Range 0..DEPTH; never over- or underflows.
- flush: at the edge all entries become invalid and count=0. Dispatch and issue in that cycle are discarded. flush has priority over everything except rst_n.
- Reset asserted mid-operation: state is cleared immediately, without waiting for a clock edge.

Test Plan:
1. Reset, then dispatch add (choice=add, src1 val=5 rdy, src2 val=7 rdy, dst=3), iss_ready=1 → next cycle iss_valid=1, d1=5, d2=7, dst_tag=3; after the edge count=0.
2. Dispatch A (src1 waits on tag 9), then B (both ready), iss_ready=1 → B issues first; cdb tag 9 data 0x100 → A issues the cycle after the wakeup with d1=0x100.
3. Fill 4 entries, all waiting on tag 2, iss_ready=0 → disp_ready=0, count=4; a fifth disp_valid is dropped. cdb tag 2 → next cycle entry 0 is offered; drain with iss_ready=1 → issue order matches dispatch order, count steps 4→0.
4. Simultaneous dispatch and issue with count=2 → count stays 2; new entry lands at index 1; its operands are correct when later issued.
5. Dispatch with src2 waiting on tag 5 while cdb_valid, tag 5, data 0xDEAD in the same cycle → entry issues next cycle with d2=0xDEAD.
6. Three valid entries, flush together with disp_valid=1 → count=0 and iss_valid=0 next cycle. Assert rst_n low between edges → iss_valid drops to 0 asynchronously.
